// File: rtl/jtlt_pkg.sv
// jtlt_pkg: shared types and limits for the JTL timing array.
// Holds the per-channel state enum, the legal parameter ranges and a
// population-count helper used by the violation counter.
package jtlt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } chan_state_e;

  localparam int N_CH_MIN  = 1;
  localparam int N_CH_MAX  = 32;
  localparam int DELAY_MIN = 1;
  localparam int DELAY_MAX = 64;
  localparam int CT_MIN    = 1;
  localparam int CT_MAX    = 64;

  // Width of the per-channel critical-timing counter (holds up to CT_MAX).
  localparam int CNT_W = $clog2(CT_MAX + 1);
  // Width of a count of simultaneously violating channels.
  localparam int POP_W = $clog2(N_CH_MAX + 1);

  // Number of set bits in a channel vector.
  function automatic logic [POP_W-1:0] popcount(input logic [N_CH_MAX-1:0] v);
    logic [POP_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < N_CH_MAX; k++) begin
      acc = acc + POP_W'(v[k]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/jtlt_chan.sv
// jtlt_chan: one JTL channel -- edge detector on the input level, the
// IDLE/BUSY/ERR timing FSM with its critical-window counter, and the event
// shift line that turns an accepted event into an output toggle DELAY cycles
// later. Optional feature macro: JTLT_ERRCNT_EN (adds o_viol).
module jtlt_chan
  import jtlt_pkg::*;
#(
  parameter int DELAY = 8,
  parameter int CT    = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  input  logic i_en,
  input  logic i_bias_ok,
  input  logic i_err_clr,
  output logic o_out,
  output logic o_err
`ifdef JTLT_ERRCNT_EN
  ,
  output logic o_viol
`endif
);

  // The stage that would hold the event during its final cycle is folded
  // into the output flop, so the registered line is one shorter than DELAY.
  localparam int DL_W = (DELAY > 1) ? (DELAY - 1) : 1;
  // The event cycle itself is the first cycle of the window, so only CT-1
  // further cycles remain once the counter is loaded.
  localparam logic [CNT_W-1:0] CT_LOAD = CNT_W'(CT - 1);

  chan_state_e       r_state;
  chan_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_prev;
  logic [DL_W-1:0]   r_dl;
  logic [DL_W-1:0]   w_dl_shift;
  logic [DL_W-1:0]   w_dl_nxt;
  logic              r_out;
  logic              w_out_nxt;
  logic              r_err;
  logic              w_event;
  logic              w_hit;
  logic              w_accept;
  logic              w_flush;
  logic              w_tap;

  assign w_event = i_in ^ r_prev;
  assign w_hit   = w_event & i_en;

  generate
    if (DELAY > 2) begin : g_line_long
      assign w_dl_shift = {r_dl[DL_W-2:0], w_accept};
    end else begin : g_line_short
      assign w_dl_shift = w_accept;
    end
    if (DELAY == 1) begin : g_tap_direct
      assign w_tap = w_accept;
    end else begin : g_tap_line
      assign w_tap = r_dl[DL_W-1];
    end
  endgenerate

`ifdef JTLT_ERRCNT_EN
  // Bias faults are not timing violations, so they are excluded here.
  assign o_viol = (r_state == ST_BUSY) & i_bias_ok & w_hit;
`endif

  // Next-state logic: bias fault overrides everything, then per-state rules.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_flush     = 1'b0;
    if (!i_bias_ok) begin
      w_state_nxt = ST_ERR;
      w_cnt_nxt   = '0;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            w_accept    = 1'b1;
            w_state_nxt = (CT > 1) ? ST_BUSY : ST_IDLE;
            w_cnt_nxt   = CT_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (w_hit) begin
            w_state_nxt = ST_ERR;
            w_cnt_nxt   = '0;
            w_flush     = 1'b1;
          end else if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
          end
        end
        ST_ERR: begin
          // A clear wins over a coincident event: the event is dropped and
          // the input history simply follows the new level.
          if (i_err_clr) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
        default: begin
          w_state_nxt = ST_ERR;
          w_cnt_nxt   = '0;
          w_flush     = 1'b1;
        end
      endcase
    end
  end

  // Delay line shift/flush and output toggle when an event leaves the line.
  always_comb begin
    w_dl_nxt  = w_dl_shift;
    w_out_nxt = r_out;
    if (w_flush) begin
      w_dl_nxt  = '0;
      w_out_nxt = r_out;
    end else begin
      w_dl_nxt  = w_dl_shift;
      w_out_nxt = r_out ^ w_tap;
    end
  end

  // Channel state registers; input history is tracked even during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_prev  <= i_in;
      r_dl    <= '0;
      r_out   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= i_in;
      r_dl    <= w_dl_nxt;
      r_out   <= w_out_nxt;
      r_err   <= (w_state_nxt == ST_ERR);
    end
  end

  assign o_out = r_out;
  assign o_err = r_err;

endmodule

// File: rtl/jtlt_array.sv
// jtlt_array: N_CH independent JTL timing channels sharing a startup
// blanking counter. Optional feature macro: JTLT_ERRCNT_EN adds the
// saturating viol_cnt output counting critical-timing violations.
module jtlt_array
  import jtlt_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DELAY   = 8,
  parameter int CT      = 9,
  parameter int STARTUP = 4,
  parameter int ERRW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  input  logic            bias_ok,
  input  logic [N_CH-1:0] err_clr,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] err
`ifdef JTLT_ERRCNT_EN
  ,
  output logic [ERRW-1:0] viol_cnt
`endif
);

  localparam int SU_W = (STARTUP < 1) ? 1 : $clog2(STARTUP + 1);

  logic [SU_W-1:0] r_su;
  logic            w_en;
  logic [N_CH-1:0] w_out;
  logic [N_CH-1:0] w_err;

  assign w_en = (r_su >= SU_W'(STARTUP));

  // Startup blanking counter: counts up after reset and parks at STARTUP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_su <= '0;
    end else if (!w_en) begin
      r_su <= r_su + SU_W'(1);
    end else begin
      r_su <= r_su;
    end
  end

`ifdef JTLT_ERRCNT_EN
  localparam int SUM_W = ERRW + POP_W;

  logic [N_CH-1:0]  w_viol;
  logic [ERRW-1:0]  r_viol_cnt;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_max;

  assign w_max = {{POP_W{1'b0}}, {ERRW{1'b1}}};
  assign w_sum = {{POP_W{1'b0}}, r_viol_cnt}
               + SUM_W'(popcount(N_CH_MAX'(w_viol)));

  // Violation counter: adds every violating channel, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_viol_cnt <= '0;
    end else if (w_sum > w_max) begin
      r_viol_cnt <= w_max[ERRW-1:0];
    end else begin
      r_viol_cnt <= w_sum[ERRW-1:0];
    end
  end

  assign viol_cnt = r_viol_cnt;
`endif

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_chan
      jtlt_chan #(
        .DELAY (DELAY),
        .CT    (CT)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_in      (in[g]),
        .i_en      (w_en),
        .i_bias_ok (bias_ok),
        .i_err_clr (err_clr[g]),
        .o_out     (w_out[g]),
        .o_err     (w_err[g])
`ifdef JTLT_ERRCNT_EN
        ,
        .o_viol    (w_viol[g])
`endif
      );
    end
  endgenerate

  assign out = w_out;
  assign err = w_err;

endmodule

// File: tb/tb_jtlt_array.sv
// tb_jtlt_array: directed scenarios on two instances (default parameters,
// and DELAY=12/CT=3). Expected output snapshots are queued when stimulus is
// issued; monitors pop one entry whenever an instance's out/err changes.
module tb_jtlt_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bias_ok;
  logic [3:0] err_clr;
  logic [3:0] a_in, b_in;
  logic [3:0] a_out, a_err, b_out, b_err;
`ifdef JTLT_ERRCNT_EN
  logic [15:0] a_viol, b_viol;
`endif

  int cyc;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] out;
    logic [3:0] err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  logic [3:0] pa_out, pa_err, pb_out, pb_err;

  always #5 clk = ~clk;

  jtlt_array u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (a_in),
    .bias_ok  (bias_ok),
    .err_clr  (err_clr),
    .out      (a_out),
    .err      (a_err)
`ifdef JTLT_ERRCNT_EN
    ,
    .viol_cnt (a_viol)
`endif
  );

  jtlt_array #(.DELAY(12), .CT(3)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (b_in),
    .bias_ok  (bias_ok),
    .err_clr  (err_clr),
    .out      (b_out),
    .err      (b_err)
`ifdef JTLT_ERRCNT_EN
    ,
    .viol_cnt (b_viol)
`endif
  );

  // Cycle 0 is the first cycle after the last reset edge.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor for instance A.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pa_out = a_out;
      pa_err = a_err;
    end else if (a_out !== pa_out || a_err !== pa_err) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected cyc=%0d out=%b err=%b (no change expected)", cyc, a_out, a_err);
      end else begin
        e = qa.pop_front();
        if (e.cyc != cyc || e.out !== a_out || e.err !== a_err) begin
          errors++;
          $display("FAIL a_change got cyc=%0d out=%b err=%b expected cyc=%0d out=%b err=%b",
                   cyc, a_out, a_err, e.cyc, e.out, e.err);
        end
      end
      pa_out = a_out;
      pa_err = a_err;
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pb_out = b_out;
      pb_err = b_err;
    end else if (b_out !== pb_out || b_err !== pb_err) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected cyc=%0d out=%b err=%b (no change expected)", cyc, b_out, b_err);
      end else begin
        e = qb.pop_front();
        if (e.cyc != cyc || e.out !== b_out || e.err !== b_err) begin
          errors++;
          $display("FAIL b_change got cyc=%0d out=%b err=%b expected cyc=%0d out=%b err=%b",
                   cyc, b_out, b_err, e.cyc, e.out, e.err);
        end
      end
      pb_out = b_out;
      pb_err = b_err;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_a(input int c, input logic [3:0] o, input logic [3:0] e);
    qa.push_back('{cyc: c, out: o, err: e});
  endtask

  task automatic push_b(input int c, input logic [3:0] o, input logic [3:0] e);
    qb.push_back('{cyc: c, out: o, err: e});
  endtask

  // Advance to 1 time unit after the rising edge that starts cycle c.
  task automatic goto(input int c);
    int n;
    n = 0;
    while (cyc != c) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 300) begin
        $display("FAIL goto_timeout cyc=%0d target=%0d", cyc, c);
        $fatal(1, "cycle target unreachable");
      end
    end
  endtask

  task automatic qchk(input string nm);
    chk({nm, "_qa_empty"}, 32'(qa.size()), 32'd0);
    chk({nm, "_qb_empty"}, 32'(qb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bias_ok = 1'b1;
    err_clr = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_a_err", 32'(a_err), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);
    chk("rst_b_err", 32'(b_err), 32'd0);
`ifdef JTLT_ERRCNT_EN
    chk("rst_a_viol", 32'(a_viol), 32'd0);
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    bias_ok = 1'b1;
    err_clr = 4'b0000;
    a_in    = 4'b0000;
    b_in    = 4'b0000;

    // Single toggle, violation, spaced events (A); overlapping flight (B).
    do_reset();
    push_a(26, 4'b0000, 4'b0010);
    push_a(28, 4'b0101, 4'b0010);
    push_a(37, 4'b0001, 4'b0010);
    push_b(32, 4'b0001, 4'b0000);
    push_b(36, 4'b0000, 4'b0000);
    push_b(40, 4'b0001, 4'b0000);
    goto(20); a_in = a_in ^ 4'b0111; b_in = b_in ^ 4'b0001;
    goto(24); b_in = b_in ^ 4'b0001;
    goto(25); a_in = a_in ^ 4'b0010;
    goto(28); b_in = b_in ^ 4'b0001;
    goto(29); a_in = a_in ^ 4'b0100;
    goto(50);
`ifdef JTLT_ERRCNT_EN
    chk("s1_a_viol", 32'(a_viol), 32'd1);
    chk("s1_b_viol", 32'(b_viol), 32'd0);
`endif
    qchk("s1");

    // Bias fault with an event in flight, clear racing an event, recovery.
    do_reset();
    push_a(31, 4'b0000, 4'b1111);
    push_a(36, 4'b0000, 4'b0000);
    push_a(48, 4'b0001, 4'b0000);
    push_b(31, 4'b0000, 4'b1111);
    push_b(36, 4'b0000, 4'b0000);
    goto(25); a_in = a_in ^ 4'b0001;
    goto(30); bias_ok = 1'b0;
    goto(31); bias_ok = 1'b1;
    goto(35); err_clr = 4'b1111; a_in = a_in ^ 4'b0010;
    goto(36); err_clr = 4'b0000;
    goto(40); a_in = a_in ^ 4'b0001;
    goto(60);
`ifdef JTLT_ERRCNT_EN
    chk("s2_a_viol", 32'(a_viol), 32'd0);
`endif
    qchk("s2");

    // Startup blanking, then reset while an event is in flight.
    do_reset();
    goto(2); a_in = a_in ^ 4'b0001; b_in = b_in ^ 4'b0001;
    goto(15);
    chk("s3_a_out_c15", 32'(a_out), 32'd0);
    chk("s3_b_out_c15", 32'(b_out), 32'd0);
    goto(20); a_in = a_in ^ 4'b0010;
    goto(23);
    do_reset();
    goto(40);
    chk("s3_a_out_end", 32'(a_out), 32'd0);
    chk("s3_a_err_end", 32'(a_err), 32'd0);
    qchk("s3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtlt_array.md
JTLT_ARRAY -- requirements
Module: jtlt_array

Interface
REQ-001 Parameter N_CH, default 4, number of independent JTL channels (1..32).
REQ-002 Parameter DELAY, default 8, input-event-to-output-toggle latency in clk cycles (1..64).
REQ-003 Parameter CT, default 9, critical-timing window in clk cycles after an accepted event (1..64).
REQ-004 Parameter STARTUP, default 4, cycles after reset release during which input events are ignored.
REQ-005 Parameter ERRW, default 16, violation-counter width.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 in  input  N_CH  per-channel SFQ level signal; any change of in[i] is one event.
REQ-009 bias_ok  input  1  bias within operating range; low forces all channels to ERR.
REQ-010 err_clr  input  N_CH  per-channel error clear pulse.
REQ-011 out  output  N_CH  per-channel output level; toggles once per propagated event.
REQ-012 err  output  N_CH  per-channel sticky error flag, high while the channel is in ERR.
REQ-013 viol_cnt  output  ERRW  total critical-timing violations (present only with JTLT_ERRCNT_EN).

Function
REQ-014 Event detection SHALL compare in[i] with its registered previous value; a difference in cycle t is an event at t.
REQ-015 Each channel SHALL have states IDLE, BUSY and ERR, with a CT-window down-counter.
REQ-016 IDLE + event: accept, load counter with CT, go BUSY.
REQ-017 BUSY: decrement counter each cycle; return to IDLE in the cycle the counter reaches 0.
REQ-018 BUSY + event: violation; go ERR and do not accept the event.
REQ-019 An accepted event at cycle t SHALL toggle out[i] at the rising edge ending cycle t+DELAY-1, so the change is visible at cycle t+DELAY.
REQ-020 The delay path SHALL be a DELAY-deep per-channel event shift line, so the CT < DELAY case keeps multiple events in flight.
REQ-021 Entry to ERR SHALL flush the channel's delay line; out[i] holds its current value and err[i]=1.
REQ-022 ERR is left only via err_clr[i]=1 (to IDLE, counter 0, with in history resampled) or reset.
REQ-023 If err_clr[i] and an event coincide, the clear wins and the event is discarded.
REQ-024 If bias_ok=0, every channel SHALL go ERR in that cycle; err_clr has no effect while bias_ok=0.
REQ-025 Events during the first STARTUP cycles after reset release SHALL be ignored, but in history is still tracked.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels are all processed.

Reset
REQ-027 With rst_n=0 at a rising edge: out=0, err=0, all states IDLE, counters 0, delay lines empty, startup counter 0, viol_cnt=0, and in history loaded from in.
REQ-028 Reset mid-operation SHALL discard in-flight events; none appear after reset release.

Configuration
REQ-029 With JTLT_ERRCNT_EN defined, viol_cnt SHALL increment by the number of channels violating in a cycle (REQ-018 only, not bias faults), saturate at all-ones, and clear only on reset.
REQ-030 Without JTLT_ERRCNT_EN, the viol_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 Package jtlt_pkg SHALL hold the channel-state enum (IDLE/BUSY/ERR) and the parameter-range limit constants.
REQ-032 Sub-module jtlt_chan SHALL implement one channel (detector, FSM, CT counter, delay line); jtlt_array instantiates N_CH copies plus the startup counter and violation counter.

Verification
REQ-033 Defaults, single toggle on in[0] at cycle 20 -> out[0] toggles visible at cycle 28; other channels stay 0.
REQ-034 Toggles on in[1] at cycles 20 and 25 -> err[1]=1 from cycle 26; out[1] never toggles; viol_cnt=1.
REQ-035 Toggles on in[2] at cycles 20 and 29 -> no error; out[2] toggles at cycles 28 and 37.
REQ-036 DELAY=12, CT=3, toggles at cycles 20, 24 and 28 -> out toggles at cycles 32, 36 and 40.
REQ-037 bias_ok low for cycle 30 with an event in flight -> err all ones, out frozen; err_clr=all ones at cycle 35 -> err cleared, a new event is accepted.
REQ-038 Toggle at cycle 2 after reset release -> ignored; rst_n low at cycle 23 after toggle at 20 -> out stays 0.
